// File: rtl/video_pkg.sv
// video_pkg: shared palette field layout and pixel pipeline constants
package video_pkg;
  localparam int PAL_R_LSB = 0;
  localparam int PAL_R_W = 3;
  localparam int PAL_G_LSB = 3;
  localparam int PAL_G_W = 3;
  localparam int PAL_B_LSB = 6;
  localparam int PAL_B_W = 2;
  localparam int PIX_LATENCY = 3;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with push/pop/clear, occupancy count and registered full
module byte_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  assign rd_data = mem[rd_ptr];
  assign count_nxt = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full <= count_nxt == CW'(DEPTH);
    end
  end
endmodule

// File: rtl/palette_pixel_reader.sv
// palette_pixel_reader: buffers packed video bytes, serialises nibbles into palette reads and unpacks RGB
module palette_pixel_reader
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_ce,
  input  logic                 de_in,
  input  logic                 flush,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic [NIBBLE_W-1:0]  pal_addr,
  input  logic [7:0]           pal_data,
  output logic [PAL_R_W-1:0]   r_out,
  output logic [PAL_G_W-1:0]   g_out,
  output logic [PAL_B_W-1:0]   b_out,
  output logic                 de_out,
  output logic                 underrun,
  input  logic                 underrun_clr
);
  logic [$clog2(FIFO_DEPTH):0] count;
  logic full, phase, empty, active, consume, pop, push;
  logic [7:0] head;
  logic [NIBBLE_W-1:0] nibble;
  logic s1_valid, s1_de, s1_black, s2_valid, s2_de, s2_black;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(flush),
    .push(push),
    .pop(pop),
    .wr_data(byte_data),
    .rd_data(head),
    .count(count),
    .full(full)
  );
  assign byte_ready = !reset && !flush && !full;
  assign push = byte_valid && byte_ready;
  assign empty = flush || count == '0;
  assign active = pix_ce && de_in;
  assign consume = active && !empty;
  assign pop = consume && phase;
  assign nibble = (phase == HI_FIRST) ? head[3:0] : head[7:4];
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      pal_addr <= '0;
      underrun <= 1'b0;
      {s1_valid, s1_de, s1_black, s2_valid, s2_de, s2_black} <= '0;
      {r_out, g_out, b_out, de_out} <= '0;
    end else begin
      phase <= flush ? 1'b0 : phase ^ consume;
      if (consume) pal_addr <= nibble;
      underrun <= (active && empty) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
      s1_valid <= pix_ce;
      if (pix_ce) {s1_de, s1_black} <= {de_in, !de_in || empty};
      s2_valid <= s1_valid;
      if (s1_valid) {s2_de, s2_black} <= {s1_de, s1_black};
      if (s2_valid) begin
        r_out <= s2_black ? '0 : pal_data[PAL_R_LSB +: PAL_R_W];
        g_out <= s2_black ? '0 : pal_data[PAL_G_LSB +: PAL_G_W];
        b_out <= s2_black ? '0 : pal_data[PAL_B_LSB +: PAL_B_W];
        de_out <= s2_de;
      end
    end
  end
endmodule

// File: doc/palette_pixel_reader.md
Name: palette_pixel_reader

Overview:
- Read-side client of the 16x8 palette RAM.
- Accepts video-RAM bytes (two 4-bit pixels per byte) over a valid/ready stream and buffers them.
- On each pixel-clock enable it serialises one nibble, drives it as the palette read address, and captures the palette byte one cycle later.
- Unpacks the palette byte into registered R/G/B with a delayed display-enable for the video output stage.

Parameters:
- FIFO_DEPTH, 2, byte buffer depth; power of two, at least 2.
- HI_FIRST, 1, 1 = bits [7:4] shown first, 0 = bits [3:0] shown first.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; one pixel slot per high cycle.
- de_in  in  1  display enable for the current pixel slot; sampled only when pix_ce=1.
- flush  in  1  discard all buffered bytes and the nibble phase (frame start).
- byte_valid  in  1  video byte offered.
- byte_data  in  8  two packed pixels.
- byte_ready  out  1  buffer can accept a byte.
- pal_addr  out  4  palette read address; connects to the RAM read-address port.
- pal_data  in  8  palette read data; RAM registered output, valid one clk after pal_addr.
- r_out  out  3  red = palette[2:0].
- g_out  out  3  green = palette[5:3].
- b_out  out  2  blue = palette[7:6].
- de_out  out  1  delayed display enable aligned with RGB.
- underrun  out  1  sticky flag: an active pixel slot found the buffer empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (synchronous, active-high). While reset=1 at an edge:
  - FIFO count=0, nibble phase=0.
  - pal_addr=0, r_out/g_out/b_out=0, de_out=0, underrun=0.
  - All pipeline valid bits=0.
  - byte_ready=0 while reset is high.
  - Reset mid-line drops any in-flight pixels; no RGB update occurs from pre-reset slots.
- Byte accept:
  - byte_ready = !reset && !flush && count<FIFO_DEPTH, computed from the registered count only.
  - A pop in the same cycle does not raise ready; there is no pass-through.
  - A byte is pushed when byte_valid && byte_ready.
- Pixel slot, evaluated at edge T when pix_ce=1:
  - de_in=0: no consumption; slot is tagged blank.
  - de_in=1 and count>0: emit the nibble selected by phase (phase 0 = first nibble per HI_FIRST), then toggle phase. When phase returns 0, pop the FIFO head.
  - de_in=1 and count=0: underrun slot. pal_addr is unchanged, the slot is tagged active-black, and underrun is set.
- Pipeline; stages advance only for tagged slots:
  - Edge T: pal_addr <= nibble (if consuming); s1_valid<=1, s1_de, s1_black.
  - Edge T+1: palette RAM registers pal_data; stage-2 tags shift.
  - Edge T+2: r/g/b <= pal_data fields, or 0 if blank or black; de_out <= tag de.
  - Total latency: 3 edges from the pix_ce sample to visible output.
- Between updates, RGB and de_out hold their values.
- pix_ce may assert on consecutive cycles; the pipeline sustains 1 pixel per clk.
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- flush:
  - count<=0, phase<=0; no push that cycle.
  - A pixel slot in the same cycle is treated as buffer-empty: underrun if de_in=1.
  - Slots already in the pipeline complete normally.
- Underrun flag: underrun_clr clears it. Set has priority over clear in the same cycle.
- The flag is sticky through flush; only reset or underrun_clr clears it.

Decomposition:
- Package video_pkg holds:
  - palette field constants PAL_R_LSB=0/W=3, PAL_G_LSB=3/W=3, PAL_B_LSB=6/W=2
  - PIX_LATENCY=3
  - NIBBLE_W=4
- Sub-module byte_fifo: synchronous FIFO with push, pop, clear, count, and registered full; depth from FIFO_DEPTH.
- Nibble phase, pipeline tags and RGB unpack stay in the top module.

Test Plan:
- Basic pixel path:
  - Stimulus: palette[A]=8'hD5, palette[3]=8'h00. Push byte 8'hA3, then pix_ce+de_in on two consecutive cycles.
  - Response: pal_addr=A then 3. RGB r=5,g=2,b=3 appears 3 edges after the first slot, then 0/0/0. de_out=1 for both.
- Back-pressure:
  - Stimulus: hold byte_valid=1 with no pix_ce.
  - Response: exactly 2 bytes accepted, byte_ready=0 after. One pop (two active slots) raises byte_ready the following cycle, not the same cycle.
- Blanking:
  - Stimulus: pix_ce=1, de_in=0 with 1 byte buffered.
  - Response: count unchanged, de_out=0, RGB=0 after 3 edges.
- Underrun:
  - Stimulus: empty buffer, pix_ce+de_in.
  - Response: underrun=1 and de_out=1 with RGB=0. underrun_clr clears it, but a new underrun in the same cycle keeps it set.
- Flush mid-byte:
  - Stimulus: consume high nibble of 8'h5C, assert flush, push 8'h71.
  - Response: the next pixels are 7 then 1 (C is never shown).
- Reset mid-stream:
  - Stimulus: assert reset with 2 slots in flight.
  - Response: all outputs 0 next edge, no RGB update from in-flight slots, byte_ready=0 during reset and 1 the cycle after release.
